// File: rtl/ycbcr_mask_bbox.sv
// ycbcr_mask_bbox: chroma-threshold mask plus per-frame bounding box of masked pixels.
// Cb/Cr and syncs arrive already aligned. Mask and syncs leave one ce-cycle later.
// The box is published at each vsync rising edge, with a one-clk bbox_valid pulse.
// Optional macro YCBCR_MASK_PIXCOUNT_EN adds a pix_count output.
// It holds the number of masked pixels in the published frame.
module ycbcr_mask_bbox #(
  parameter int N  = 8,
  parameter int XW = 11,
  parameter int YW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          de_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [N-1:0]  cb_in,
  input  logic [N-1:0]  cr_in,
  input  logic [N-1:0]  cb_min,
  input  logic [N-1:0]  cb_max,
  input  logic [N-1:0]  cr_min,
  input  logic [N-1:0]  cr_max,
  output logic          de_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          mask_out,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic          bbox_found,
  output logic          bbox_valid
`ifdef YCBCR_MASK_PIXCOUNT_EN
  ,
  output logic [XW+YW-1:0] pix_count
`endif
);

  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

  state_t          state_reg, state_next;
  logic            hit, vs_rise, de_fall;
  logic            accumulate, publish, clear_acc;
  logic [XW-1:0]   x_reg;
  logic [YW-1:0]   y_reg;
  logic [XW-1:0]   x_min_acc, x_max_acc;
  logic [YW-1:0]   y_min_acc, y_max_acc;
  logic            found_acc;

  // de_out/vsync_out already hold the previous ce-sampled de_in/vsync_in, so they double as edge history.
  // An inverted threshold pair (min>max) can never satisfy both compares, so it yields no hit.
  assign hit     = de_in & (cb_in >= cb_min) & (cb_in <= cb_max)
                         & (cr_in >= cr_min) & (cr_in <= cr_max);
  assign vs_rise = vsync_in & ~vsync_out;
  assign de_fall = ~de_in & de_out;

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= WAIT_FRAME;
    else     state_reg <= state_next;
  end

  // Next state and accumulator controls; a pixel coinciding with vsync rise is never accumulated
  always_comb begin
    state_next = state_reg;
    accumulate = 1'b0;
    publish    = 1'b0;
    clear_acc  = 1'b0;
    if (ce) begin
      case (state_reg)
        WAIT_FRAME: begin
          if (vs_rise) begin
            state_next = ACTIVE;
            clear_acc  = 1'b1;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            publish   = 1'b1;
            clear_acc = 1'b1;
          end else if (hit) begin
            accumulate = 1'b1;
          end
        end
        default: state_next = WAIT_FRAME;
      endcase
    end
  end

  // One-cycle pass-through of syncs and the mask
  always_ff @(posedge clk) begin
    if (rst) begin
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      mask_out  <= 1'b0;
    end else if (ce) begin
      de_out    <= de_in;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      mask_out  <= hit;
    end
  end

  // Saturating column/line counters; the current values are the coordinate of this pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (ce) begin
      if (de_in) x_reg <= (&x_reg) ? x_reg : x_reg + 1'b1;
      else       x_reg <= '0;
      if (vs_rise)      y_reg <= '0;
      else if (de_fall) y_reg <= (&y_reg) ? y_reg : y_reg + 1'b1;
    end
  end

  // Running min/max of hit coordinates for the frame in progress
  always_ff @(posedge clk) begin
    if (rst || clear_acc) begin
      x_min_acc <= '1;
      x_max_acc <= '0;
      y_min_acc <= '1;
      y_max_acc <= '0;
      found_acc <= 1'b0;
    end else if (accumulate) begin
      if (x_reg < x_min_acc) x_min_acc <= x_reg;
      if (x_reg > x_max_acc) x_max_acc <= x_reg;
      if (y_reg < y_min_acc) y_min_acc <= y_reg;
      if (y_reg > y_max_acc) y_max_acc <= y_reg;
      found_acc <= 1'b1;
    end
  end

  // Published box; an empty frame publishes zeros rather than the sentinel min values
  always_ff @(posedge clk) begin
    if (rst) begin
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      bbox_found <= 1'b0;
    end else if (publish) begin
      x_min      <= found_acc ? x_min_acc : '0;
      x_max      <= found_acc ? x_max_acc : '0;
      y_min      <= found_acc ? y_min_acc : '0;
      y_max      <= found_acc ? y_max_acc : '0;
      bbox_found <= found_acc;
    end
  end

  // bbox_valid ignores ce on the falling side so the pulse is exactly one clk wide
  always_ff @(posedge clk) begin
    if (rst) bbox_valid <= 1'b0;
    else     bbox_valid <= publish;
  end

`ifdef YCBCR_MASK_PIXCOUNT_EN
  logic [XW+YW-1:0] pix_acc;

  // Saturating hit counter with the same clear/publish timing as the box
  always_ff @(posedge clk) begin
    if (rst || clear_acc)  pix_acc <= '0;
    else if (accumulate)   pix_acc <= (&pix_acc) ? pix_acc : pix_acc + 1'b1;
  end

  // Published pixel count
  always_ff @(posedge clk) begin
    if (rst)          pix_count <= '0;
    else if (publish) pix_count <= pix_acc;
  end
`endif

endmodule

// File: tb/tb_ycbcr_mask_bbox.sv
// Directed testbench for ycbcr_mask_bbox.
// Frames are 8 pixels x 4 lines with 2 blank cycles per line.
// Each vsync pulse is 2 cycles high followed by 2 cycles low.
module tb_ycbcr_mask_bbox;

  logic        clk = 1'b0;
  logic        rst, ce, de_in, hsync_in, vsync_in;
  logic [7:0]  cb_in, cr_in, cb_min, cb_max, cr_min, cr_max;
  logic        de_out, hsync_out, vsync_out, mask_out;
  logic [10:0] x_min, x_max, y_min, y_max;
  logic        bbox_found, bbox_valid;
`ifdef YCBCR_MASK_PIXCOUNT_EN
  logic [21:0] pix_count;
`endif

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  bit ce_mode = 0;

  ycbcr_mask_bbox dut (
    .clk(clk), .rst(rst), .ce(ce),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cb_in(cb_in), .cr_in(cr_in),
    .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .mask_out(mask_out),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .bbox_found(bbox_found), .bbox_valid(bbox_valid)
`ifdef YCBCR_MASK_PIXCOUNT_EN
    , .pix_count(pix_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bbox_valid) valid_cnt++;
  endtask

  // Drive one pixel cycle.
  // In ce_mode the same inputs are held for one ce=1 clk and then one ce=0 clk.
  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic [7:0] cb, input logic [7:0] cr, input logic exp_mask);
    de_in = de; hsync_in = hs; vsync_in = vs; cb_in = cb; cr_in = cr; ce = 1'b1;
    tick();
    checks++;
    if ({de_out, hsync_out, vsync_out, mask_out} !== {de, hs, vs, exp_mask}) begin
      errors++;
      $display("FAIL passthru got de/hs/vs/mask=%b required %b", {de_out, hsync_out, vsync_out, mask_out}, {de, hs, vs, exp_mask});
    end
    if (ce_mode) begin
      ce = 1'b0;
      tick();
      checks++;
      if ({de_out, hsync_out, vsync_out, mask_out} !== {de, hs, vs, exp_mask}) begin
        errors++;
        $display("FAIL ce_hold got de/hs/vs/mask=%b required %b", {de_out, hsync_out, vsync_out, mask_out}, {de, hs, vs, exp_mask});
      end
      ce = 1'b1;
    end
  endtask

  function automatic bit is_blob(int c, int l);
    return (c == 2 && l == 1) || (c == 5 && l == 1) || (c == 3 && l == 2);
  endfunction

  task automatic run_frame(input bit blob, input int nlines);
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < 8; c++) begin
        if (blob && is_blob(c, l)) step(1'b1, 1'b0, 1'b0, 8'd120, 8'd120, 1'b1);
        else                       step(1'b1, 1'b0, 1'b0, 8'd50, 8'd50, 1'b0);
      end
      step(1'b0, 1'b1, 1'b0, 8'd50, 8'd50, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'd50, 8'd50, 1'b0);
    end
  endtask

  task automatic vsync_pulse();
    step(1'b0, 1'b0, 1'b1, 8'd50, 8'd50, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd50, 8'd50, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd50, 8'd50, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd50, 8'd50, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ce = 1'($urandom); de_in = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      cb_in = 8'($urandom); cr_in = 8'($urandom);
      tick();
    end
    checks++;
    if ({de_out, hsync_out, vsync_out, mask_out, x_min, x_max, y_min, y_max, bbox_found, bbox_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", {de_out, hsync_out, vsync_out, mask_out, x_min, x_max, y_min, y_max, bbox_found, bbox_valid});
    end
`ifdef YCBCR_MASK_PIXCOUNT_EN
    checks++;
    if (pix_count !== '0) begin
      errors++;
      $display("FAIL reset_pix_count got %0d required 0", pix_count);
    end
`endif
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'd50, 8'd50, 1'b0);
    valid_cnt = 0;
    vsync_pulse();
    checks++;
    if (valid_cnt !== 0) begin
      errors++;
      $display("FAIL first_vsync_valid got %0d pulses required 0", valid_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_blob(input string name);
    run_frame(1'b1, 4);
    valid_cnt = 0;
    vsync_pulse();
    checks++;
    if (valid_cnt !== 1) begin
      errors++;
      $display("FAIL %s_valid_width got %0d clks required 1", name, valid_cnt);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max, bbox_found} !== {11'd2, 11'd5, 11'd1, 11'd2, 1'b1}) begin
      errors++;
      $display("FAIL %s_box got x %0d..%0d y %0d..%0d found %0b required x 2..5 y 1..2 found 1",
               name, x_min, x_max, y_min, y_max, bbox_found);
    end
`ifdef YCBCR_MASK_PIXCOUNT_EN
    checks++;
    if (pix_count !== 22'd3) begin
      errors++;
      $display("FAIL %s_pix_count got %0d required 3", name, pix_count);
    end
`endif
    $display("%s box x %0d..%0d y %0d..%0d found %0b", name, x_min, x_max, y_min, y_max, bbox_found);
  endtask

  task automatic test_empty();
    run_frame(1'b0, 4);
    checks++;
    if ({x_min, x_max, y_min, y_max, bbox_found} !== {11'd2, 11'd5, 11'd1, 11'd2, 1'b1}) begin
      errors++;
      $display("FAIL empty_hold got x %0d..%0d y %0d..%0d found %0b required prior box held",
               x_min, x_max, y_min, y_max, bbox_found);
    end
    valid_cnt = 0;
    vsync_pulse();
    checks++;
    if (valid_cnt !== 1) begin
      errors++;
      $display("FAIL empty_valid_width got %0d clks required 1", valid_cnt);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max, bbox_found} !== '0) begin
      errors++;
      $display("FAIL empty_box got x %0d..%0d y %0d..%0d found %0b required all 0",
               x_min, x_max, y_min, y_max, bbox_found);
    end
`ifdef YCBCR_MASK_PIXCOUNT_EN
    checks++;
    if (pix_count !== '0) begin
      errors++;
      $display("FAIL empty_pix_count got %0d required 0", pix_count);
    end
`endif
    $display("test_empty found %0b", bbox_found);
  endtask

  task automatic test_ce_gating();
    ce_mode = 1;
    test_blob("ce_gated");
    ce_mode = 0;
  endtask

  task automatic test_boundary();
    step(1'b1, 1'b0, 1'b0, 8'd100, 8'd150, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'd99, 8'd150, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd150, 8'd151, 1'b0);
    cb_min = 8'd151;
    step(1'b1, 1'b0, 1'b0, 8'd150, 8'd120, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd151, 8'd120, 1'b0);
    cb_min = 8'd100;
    step(1'b1, 1'b0, 1'b0, 8'd150, 8'd100, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd120, 8'd120, 1'b0);
    $display("test_boundary done");
  endtask

  task automatic test_reset_mid_frame();
    run_frame(1'b1, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    valid_cnt = 0;
    vsync_pulse();
    run_frame(1'b0, 4);
    checks++;
    if (valid_cnt !== 0) begin
      errors++;
      $display("FAIL midreset_no_publish got %0d pulses required 0", valid_cnt);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max, bbox_found} !== '0) begin
      errors++;
      $display("FAIL midreset_box got x %0d..%0d y %0d..%0d found %0b required all 0",
               x_min, x_max, y_min, y_max, bbox_found);
    end
    vsync_pulse();
    checks++;
    if (valid_cnt !== 1) begin
      errors++;
      $display("FAIL midreset_second_vsync got %0d pulses required 1", valid_cnt);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max, bbox_found} !== '0) begin
      errors++;
      $display("FAIL midreset_publish got x %0d..%0d y %0d..%0d found %0b required all 0",
               x_min, x_max, y_min, y_max, bbox_found);
    end
    $display("test_reset_mid_frame done");
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    cb_in = 8'd0; cr_in = 8'd0;
    cb_min = 8'd100; cb_max = 8'd150; cr_min = 8'd100; cr_max = 8'd150;
    test_reset();
    test_blob("blob");
    test_empty();
    test_ce_gating();
    test_boundary();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
